// File: rtl/key_rotate_inverse_sched.sv
// Decrypt-side key schedule: replays the round keys from the final round down to round 1,
// undoing the per-round left rotation by rotating each half right between emissions.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last key/round
// EMIT  | key_out/round_num valid, advancing one round per accepted transfer
module key_rotate_inverse_sched #(
    parameter int          ROUNDS    = 16,
    parameter int          HALF_W    = 32,
    parameter logic [31:0] ONE_SHIFT = 32'h0000_8103
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  start,
    input  logic [0:2*HALF_W-1]   key_in,
    input  logic                  key_ready,
    output logic                  key_valid,
    output logic [0:2*HALF_W-1]   key_out,
    output logic [4:0]            round_num,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [0:2*HALF_W-1] key_q, key_d;
    logic [4:0]          round_q, round_d;
    logic                done_q, done_d;

    logic [HALF_W-1:0]   c_half, d_half, c_rot, d_rot;
    logic                shift_one;

    // Halves rotate independently; round_q of 0 only occurs in IDLE where the result is unused.
    always_comb begin
        c_half    = key_q[0:HALF_W-1];
        d_half    = key_q[HALF_W:2*HALF_W-1];
        shift_one = ONE_SHIFT[round_q - 5'd1];
        if (shift_one) begin
            c_rot = {c_half[0], c_half[HALF_W-1:1]};
            d_rot = {d_half[0], d_half[HALF_W-1:1]};
        end else begin
            c_rot = {c_half[1:0], c_half[HALF_W-1:2]};
            d_rot = {d_half[1:0], d_half[HALF_W-1:2]};
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            key_d   = '0;
            round_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_d   = key_in;
                        round_d = 5'(ROUNDS);
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        if (round_q == 5'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            key_d   = {c_rot, d_rot};
                            round_d = round_q - 5'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign key_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign key_out   = key_q;
    assign round_num = round_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_rotate_inverse_sched.sv
// Randomized bench for key_rotate_inverse_sched against a closed-form model:
// the key for round r is the loaded key with each half rotated right by the summed shifts of rounds r+1..ROUNDS.
module tb_key_rotate_inverse_sched;

    localparam int          ROUNDS    = 16;
    localparam logic [31:0] ONE_SHIFT = 32'h0000_8103;

    logic        clk = 1'b0;
    logic        rst_n, clr, start, key_ready;
    logic [0:63] key_in, key_out;
    logic        key_valid, busy, done;
    logic [4:0]  round_num;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_rotate_inverse_sched #(
        .ROUNDS(ROUNDS), .HALF_W(32), .ONE_SHIFT(ONE_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .key_in(key_in),
        .key_ready(key_ready), .key_valid(key_valid), .key_out(key_out),
        .round_num(round_num), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x >> m) | (x << (32 - m));
    endfunction

    function automatic int shift_of(input int r);
        return (((ONE_SHIFT >> (r - 1)) & 32'd1) != 0) ? 1 : 2;
    endfunction

    function automatic logic [63:0] model_key(input logic [63:0] k, input int r);
        int n;
        n = 0;
        for (int q = r + 1; q <= ROUNDS; q++) n += shift_of(q);
        return {rotr32(k[63:32], n), rotr32(k[31:0], n)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(key_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_round"}, 64'(round_num), 64'd0);
        chk({tag, "_key"},   key_out,        64'd0);
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random
    task automatic run_seq(input logic [63:0] k, input int mode, input int restart_r,
                           input int clr_r, input bit restart_on_done, input logic [63:0] k2);
        int  exp_r;
        int  cyc;
        bit  fin;
        bit  rdy;
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        exp_r  = ROUNDS;
        cyc    = 0;
        fin    = 1'b0;
        while (!fin && cyc < 200) begin
            cyc++;
            case (mode)
                0:       key_ready = 1'b1;
                1:       key_ready = (cyc % 2 == 0);
                default: key_ready = 1'($urandom_range(0, 1));
            endcase
            #4;
            chk("emit_valid", 64'(key_valid), 64'd1);
            chk("emit_busy",  64'(busy),      64'd1);
            chk("emit_round", 64'(round_num), 64'(exp_r));
            chk("emit_key",   key_out,        model_key(k, exp_r));
            if (exp_r == clr_r) clr = 1'b1;
            if (exp_r == restart_r) begin
                start  = 1'b1;
                key_in = ~k;
            end
            rdy = key_ready;
            tick();
            clr   = 1'b0;
            start = 1'b0;
            if (exp_r == clr_r) begin
                chk_idle("clr");
                tick();
                chk("clr_done_after", 64'(done), 64'd0);
                fin = 1'b1;
            end else if (rdy) begin
                if (exp_r == 1) begin
                    chk("end_valid", 64'(key_valid), 64'd0);
                    chk("end_busy",  64'(busy),      64'd0);
                    chk("end_done",  64'(done),      64'd1);
                    chk("end_key",   key_out,        model_key(k, 1));
                    if (restart_on_done) begin
                        start  = 1'b1;
                        key_in = k2;
                        tick();
                        start  = 1'b0;
                        chk("rs_done",  64'(done),      64'd0);
                        chk("rs_valid", 64'(key_valid), 64'd1);
                        chk("rs_round", 64'(round_num), 64'(ROUNDS));
                        chk("rs_key",   key_out,        model_key(k2, ROUNDS));
                        clr = 1'b1;
                        tick();
                        clr = 1'b0;
                        chk_idle("rs_clr");
                    end else begin
                        tick();
                        chk("post_done",  64'(done),      64'd0);
                        chk("post_valid", 64'(key_valid), 64'd0);
                    end
                    fin = 1'b1;
                end else begin
                    exp_r--;
                end
            end
        end
        if (!fin) chk("seq_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0] rk;
        rst_n     = 1'b0;
        clr       = 1'b0;
        start     = 1'b0;
        key_ready = 1'b1;
        key_in    = '0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("idle");

        // Directed first two keys
        start  = 1'b1;
        key_in = 64'h80000001_00000003;
        tick();
        start  = 1'b0;
        #4;
        chk("t2_key16",   key_out,        64'h80000001_00000003);
        chk("t2_round16", 64'(round_num), 64'd16);
        tick();
        #4;
        chk("t2_key15",   key_out,        64'hC0000000_80000001);
        chk("t2_round15", 64'(round_num), 64'd15);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_idle("t2_clr");

        // Full run, round-1 key must come out as 20_20
        run_seq(64'h00000001_00000001, 0, -1, -1, 1'b0, 64'd0);
        chk("t3_round1_key", key_out, 64'h00000020_00000020);

        run_seq({$urandom, $urandom}, 1, -1, -1, 1'b0, 64'd0);
        run_seq({$urandom, $urandom}, 2, 10, -1, 1'b0, 64'd0);
        run_seq({$urandom, $urandom}, 0, -1, 5, 1'b0, 64'd0);
        run_seq({$urandom, $urandom}, 2, -1, -1, 1'b1, {$urandom, $urandom});

        // Asynchronous reset mid-sequence at round 9
        key_ready = 1'b1;
        start     = 1'b1;
        key_in    = {$urandom, $urandom};
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2;
        chk("rst_pre_round", 64'(round_num), 64'd9);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        #1;
        rst_n = 1'b1;
        tick();
        chk_idle("rst_after");

        for (int i = 0; i < 4; i++) begin
            rk = {$urandom, $urandom};
            run_seq(rk, int'($urandom_range(0, 2)), -1, -1, 1'b0, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
